conditional_unit: RTL and testbench



---
 rtl/conditional_unit.sv | 24 ++
 tb/tb_conditional_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/conditional_unit.sv
// conditional_unit: condition-code check on live ALU flags plus architectural flag register; define COND_OUT_REG_EN to register out
module conditional_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ALUFlags,
  input  logic [2:0] cond,
  input  logic       FlagW,
  output logic       out,
  output logic [3:0] Flags
);
  logic n, z, c, v, pass;
  logic [7:0] tbl;
  assign {n, z, c, v} = ALUFlags;
  always_comb begin
    tbl  = {c, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~z, z, 1'b1};
    pass = tbl[cond];
  end
  always_ff @(posedge clk) Flags <= reset ? 4'b0000 : FlagW ? ALUFlags : Flags;
`ifdef COND_OUT_REG_EN
  always_ff @(posedge clk) out <= reset ? 1'b0 : pass;
`else
  assign out = pass;
`endif
endmodule

// File: tb/tb_conditional_unit.sv
// tb_conditional_unit: vector table, exhaustive and random checks of conditional_unit (handles COND_OUT_REG_EN builds)
module tb_conditional_unit;
  logic clk = 0, reset = 0, FlagW = 0, out;
  logic [3:0] ALUFlags = 0, Flags;
  logic [2:0] cond = 0;
  int n_cmp = 0, n_bad = 0;

  conditional_unit dut (.clk(clk), .reset(reset), .ALUFlags(ALUFlags), .cond(cond),
                        .FlagW(FlagW), .out(out), .Flags(Flags));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] c; logic [3:0] f; logic e;} vec_t;
  vec_t vecs[16];

  function automatic logic ref_pass(input logic [2:0] c, input logic [3:0] f);
    bit is_neg = f[3], is_zero = f[2], carry = f[1], ovf = f[0];
    bit signed_less = (is_neg != ovf);
    case (c)
      3'd0: return 1;
      3'd1: return is_zero;
      3'd2: return !is_zero;
      3'd3: return !signed_less;
      3'd4: return signed_less;
      3'd5: return !is_zero && !signed_less;
      3'd6: return is_zero || signed_less;
      default: return carry;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [2:0] c, input logic [3:0] f, input logic e);
    cond = c;
    ALUFlags = f;
`ifdef COND_OUT_REG_EN
    @(posedge clk);
`endif
    #1 chk(name, {3'b0, out}, {3'b0, e});
  endtask

  initial begin
    logic [3:0] exp_flags;
    logic exp_out;
    vecs = '{
      '{3'b001, 4'b0100, 1}, '{3'b001, 4'b1011, 0},
      '{3'b010, 4'b0100, 0}, '{3'b010, 4'b1011, 1},
      '{3'b011, 4'b1001, 1}, '{3'b011, 4'b1000, 0},
      '{3'b100, 4'b0001, 1}, '{3'b100, 4'b1001, 0},
      '{3'b101, 4'b1001, 1}, '{3'b101, 4'b0110, 0},
      '{3'b110, 4'b1100, 1}, '{3'b110, 4'b0001, 1},
      '{3'b111, 4'b0010, 1}, '{3'b111, 4'b1101, 0},
      '{3'b000, 4'b0000, 1}, '{3'b011, 4'b0110, 1}};

    // reset beats a simultaneous flag write
    @(posedge clk); #1;
    reset = 1; FlagW = 1; ALUFlags = 4'b1111; cond = 3'b000;
    @(posedge clk); #1;
    chk("reset_flags", Flags, 4'b0000);
`ifdef COND_OUT_REG_EN
    chk("reset_out_reg", {3'b0, out}, 4'b0000);
`endif
    reset = 0; FlagW = 0;
    check_out("reset_al", 3'b000, 4'b1111, 1'b1);

    foreach (vecs[i]) check_out($sformatf("vec%0d", i), vecs[i].c, vecs[i].f, vecs[i].e);

    for (int i = 0; i < 128; i++)
      check_out($sformatf("exh_c%0d_f%0d", i[6:4], i[3:0]), i[6:4], i[3:0], ref_pass(i[6:4], i[3:0]));

    // flag write then hold
    FlagW = 1; ALUFlags = 4'b1010;
    @(posedge clk); #1;
    chk("flag_write", Flags, 4'b1010);
    FlagW = 0; ALUFlags = 4'b0101;
    #3 chk("flag_no_comb", Flags, 4'b1010);
    @(posedge clk); #1;
    chk("flag_hold", Flags, 4'b1010);

    reset = 1; FlagW = 1; ALUFlags = 4'b0111;
    @(posedge clk); #1;
    chk("reset_vs_write", Flags, 4'b0000);
    reset = 0; FlagW = 0;

`ifdef COND_OUT_REG_EN
    cond = 3'b001; ALUFlags = 4'b0000;
    @(posedge clk); #1;
    chk("reg_pre", {3'b0, out}, 4'b0000);
    cond = 3'b010;
    #3 chk("reg_no_comb", {3'b0, out}, 4'b0000);
    @(posedge clk); #1;
    chk("reg_latency", {3'b0, out}, 4'b0001);
    reset = 1;
    @(posedge clk); #1;
    chk("reg_reset", {3'b0, out}, 4'b0000);
    reset = 0;
`else
    cond = 3'b010; ALUFlags = 4'b0000; reset = 1;
    #1 chk("comb_ignores_reset", {3'b0, out}, 4'b0001);
    @(posedge clk); #1;
    reset = 0;
`endif

    exp_flags = Flags;
    exp_out = out;
    for (int i = 0; i < 300; i++) begin
      cond = 3'($urandom);
      ALUFlags = 4'($urandom);
      FlagW = 1'($urandom);
      reset = ($urandom_range(0, 15) == 0);
`ifndef COND_OUT_REG_EN
      #1 chk($sformatf("rnd_out%0d", i), {3'b0, out}, {3'b0, ref_pass(cond, ALUFlags)});
`endif
      @(posedge clk);
      exp_flags = reset ? 4'b0000 : FlagW ? ALUFlags : exp_flags;
      exp_out = reset ? 1'b0 : ref_pass(cond, ALUFlags);
      #1 chk($sformatf("rnd_flags%0d", i), Flags, exp_flags);
`ifdef COND_OUT_REG_EN
      chk($sformatf("rnd_out%0d", i), {3'b0, out}, {3'b0, exp_out});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
